// File: rtl/uart_cmd_parser.sv
// Command-frame parser behind the UART receiver. It assembles SOF/OP/ADDR/DH/DL/CHK frames,
// checks the XOR checksum and the inter-byte gap, and offers {op, addr, wdata} on valid/ready.
module uart_cmd_parser #(
    parameter int          CLK_FREQ     = 100000000,
    parameter int          BAUD_RATE    = 115200,
    parameter int          TIMEOUT_BITS = 20,
    parameter logic [7:0]  SOF_BYTE     = 8'hA5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        cmd_valid,
    input  logic        cmd_ready,
    output logic [7:0]  cmd_op,
    output logic [7:0]  cmd_addr,
    output logic [15:0] cmd_wdata,
    output logic        err_chk,
    output logic        err_timeout,
    output logic        err_overrun,
    output logic        busy
);
    localparam int TIMEOUT_TICKS = (CLK_FREQ / BAUD_RATE) * TIMEOUT_BITS;
    localparam int CW = (TIMEOUT_TICKS > 1) ? $clog2(TIMEOUT_TICKS) : 1;
    localparam logic [CW-1:0] TO_LOAD = CW'(TIMEOUT_TICKS - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_OP, S_ADDR, S_DH, S_DL, S_CHK, S_HOLD
    } state_t;

    state_t        state;
    logic [7:0]    acc;
    logic [CW-1:0] cnt;

    assign busy = (state != S_IDLE);

    // Handshake: a command transfers on any rising edge where cmd_valid && cmd_ready are both
    // high; cmd_valid is never withdrawn before that and cmd_op/addr/wdata do not change while it is up.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            acc         <= '0;
            cnt         <= '0;
            cmd_valid   <= 1'b0;
            cmd_op      <= '0;
            cmd_addr    <= '0;
            cmd_wdata   <= '0;
            err_chk     <= 1'b0;
            err_timeout <= 1'b0;
            err_overrun <= 1'b0;
        end else begin
            err_chk     <= 1'b0;
            err_timeout <= 1'b0;
            err_overrun <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (rx_valid && rx_data == SOF_BYTE) begin
                        state <= S_OP;
                        acc   <= '0;
                        cnt   <= TO_LOAD;
                    end
                end
                S_HOLD: begin
                    // Any byte arriving while a command is pending is dropped, even a SOF.
                    if (rx_valid) err_overrun <= 1'b1;
                    if (cmd_valid && cmd_ready) begin
                        cmd_valid <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
                default: begin
                    if (rx_valid) begin
                        cnt <= TO_LOAD;
                        acc <= acc ^ rx_data;
                        case (state)
                            S_OP:   begin cmd_op          <= rx_data; state <= S_ADDR; end
                            S_ADDR: begin cmd_addr        <= rx_data; state <= S_DH;   end
                            S_DH:   begin cmd_wdata[15:8] <= rx_data; state <= S_DL;   end
                            S_DL:   begin cmd_wdata[7:0]  <= rx_data; state <= S_CHK;  end
                            S_CHK: begin
                                if ((acc ^ rx_data) == 8'h00) begin
                                    state     <= S_HOLD;
                                    cmd_valid <= 1'b1;
                                end else begin
                                    state   <= S_IDLE;
                                    err_chk <= 1'b1;
                                end
                            end
                            default: state <= S_IDLE;
                        endcase
                    end else if (cnt == '0) begin
                        state       <= S_IDLE;
                        err_timeout <= 1'b1;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_cmd_parser.sv
// Self-checking bench for uart_cmd_parser: table of frames, hand-written corner sequences and
// random byte streams, all compared against a frame-level reference model.
module tb_uart_cmd_parser;
    localparam int TO_TICKS = (1000 / 100) * 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  rx_data = '0;
    logic        rx_valid = 1'b0;
    logic        cmd_ready = 1'b0;
    logic        cmd_valid, err_chk, err_timeout, err_overrun, busy;
    logic [7:0]  cmd_op, cmd_addr;
    logic [15:0] cmd_wdata;

    uart_cmd_parser #(
        .CLK_FREQ(1000), .BAUD_RATE(100), .TIMEOUT_BITS(3), .SOF_BYTE(8'hA5)
    ) dut (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .err_chk(err_chk),
        .err_timeout(err_timeout), .err_overrun(err_overrun), .busy(busy)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Frame-level view: a list of bytes collected after SOF, an elapsed-idle counter,
    // and a pending-command flag.
    logic [31:0] exp_q[$];
    logic [7:0]  m_frame[$];
    bit          m_in_frame, m_pending, m_chk, m_to, m_ov;
    int          m_gap;
    logic [31:0] m_cmd;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_in_frame = 0; m_pending = 0; m_gap = 0;
            m_chk = 0; m_to = 0; m_ov = 0;
            m_frame.delete();
            exp_q.delete();
        end else begin
            m_chk = 0; m_to = 0; m_ov = 0;
            if (m_pending) begin
                if (rx_valid) m_ov = 1;
                if (cmd_ready) m_pending = 0;
            end else if (m_in_frame) begin
                if (rx_valid) begin
                    m_frame.push_back(rx_data);
                    m_gap = 0;
                    if (m_frame.size() == 5) begin
                        m_in_frame = 0;
                        if ((m_frame[0] ^ m_frame[1] ^ m_frame[2] ^ m_frame[3]) == m_frame[4]) begin
                            m_pending = 1;
                            m_cmd = {m_frame[0], m_frame[1], m_frame[2], m_frame[3]};
                            exp_q.push_back(m_cmd);
                        end else begin
                            m_chk = 1;
                        end
                    end
                end else begin
                    m_gap++;
                    if (m_gap == TO_TICKS) begin
                        m_to = 1;
                        m_in_frame = 0;
                    end
                end
            end else if (rx_valid && rx_data == 8'hA5) begin
                m_in_frame = 1;
                m_gap = 0;
                m_frame.delete();
            end
        end
    end

    // ---------------- monitor / scoreboard ----------------
    int          n_cmd = 0, n_chk = 0, n_to = 0, n_ov = 0;
    logic [31:0] last_cmd = '0;

    always @(negedge clk) begin
        if (rst) begin
            check("reset_outputs",
                  {cmd_valid, busy, err_chk, err_timeout, err_overrun, cmd_op, cmd_addr, cmd_wdata}, '0);
        end else begin
            check("cycle_flags", {cmd_valid, busy, err_chk, err_timeout, err_overrun},
                  {m_pending, m_in_frame | m_pending, m_chk, m_to, m_ov});
            if (m_pending) check("held_fields", {cmd_op, cmd_addr, cmd_wdata}, m_cmd);
            if (err_chk) n_chk++;
            if (err_timeout) n_to++;
            if (err_overrun) n_ov++;
            if (cmd_valid && cmd_ready) begin
                n_cmd++;
                last_cmd = {cmd_op, cmd_addr, cmd_wdata};
                check("sb_has_entry", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) check("sb_cmd", last_cmd, exp_q.pop_front());
            end
        end
    end

    // ---------------- driver tasks ----------------
    bit rand_ready = 0;

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_ready) cmd_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [47:0] f, input int nbytes, input int gap);
        for (int i = 0; i < nbytes; i++) begin
            send_byte(f[47 - 8*i -: 8]);
            idle(gap);
        end
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [47:0] bytes;
        int          nbytes;
        int          ready_lat;
        bit          exp_cmd;
        logic [31:0] exp_fields;
        int          exp_chk;
        int          exp_to;
    } vec_t;

    vec_t vecs[9];
    int   c0, k0, t0, o0;

    task automatic snap();
        c0 = n_cmd; k0 = n_chk; t0 = n_to; o0 = n_ov;
    endtask

    initial begin
        logic [7:0]  fb[6];
        logic [47:0] fr;
        int          nb, gap;

        vecs[0] = '{48'hA5_01_10_12_34_37, 6, 0,  1, 32'h0110_1234, 0, 0};
        vecs[1] = '{48'hA5_02_20_00_01_23, 6, 0,  1, 32'h0220_0001, 0, 0};
        vecs[2] = '{48'hA5_01_10_12_34_36, 6, 0,  0, 32'h0,         1, 0};
        vecs[3] = '{48'hA5_01_00_00_00_00, 2, 0,  0, 32'h0,         0, 1};
        vecs[4] = '{48'hA5_A5_A5_A5_A5_00, 6, 0,  1, 32'hA5A5_A5A5, 0, 0};
        vecs[5] = '{48'hA5_FF_00_FF_00_00, 6, 0,  1, 32'hFF00_FF00, 0, 0};
        vecs[6] = '{48'hA5_7E_81_C3_3C_00, 6, 10, 1, 32'h7E81_C33C, 0, 0};
        vecs[7] = '{48'hA5_12_34_56_78_00, 6, 0,  0, 32'h0,         1, 0};
        vecs[8] = '{48'hA5_11_22_33_44_00, 5, 0,  0, 32'h0,         0, 1};

        idle(3);
        rst = 1'b0;
        tick();

        foreach (vecs[v]) begin
            snap();
            cmd_ready = (vecs[v].ready_lat == 0);
            send_frame(vecs[v].bytes, vecs[v].nbytes, 1);
            idle(vecs[v].ready_lat);
            cmd_ready = 1'b1;
            idle(TO_TICKS + 5);
            check("vec_cmd_count", n_cmd - c0, vecs[v].exp_cmd);
            check("vec_err_chk",   n_chk - k0, vecs[v].exp_chk);
            check("vec_err_to",    n_to - t0,  vecs[v].exp_to);
            check("vec_err_ov",    n_ov - o0,  0);
            if (vecs[v].exp_cmd) check("vec_fields", last_cmd, vecs[v].exp_fields);
            check("vec_idle_busy", busy, 0);
        end

        // Leading junk is ignored without errors.
        snap();
        send_byte(8'h00); check("junk_busy0", busy, 0);
        send_byte(8'hFF); check("junk_busy1", busy, 0);
        send_byte(8'h55); check("junk_busy2", busy, 0);
        send_frame(48'hA5_02_20_00_01_23, 6, 0);
        idle(3);
        check("junk_cmd_count", n_cmd - c0, 1);
        check("junk_fields", last_cmd, 32'h0220_0001);
        check("junk_errs", (n_chk - k0) + (n_to - t0) + (n_ov - o0), 0);

        // Gap of exactly the limit between bytes is tolerated.
        snap();
        send_frame(48'hA5_01_10_12_34_37, 6, TO_TICKS - 1);
        idle(3);
        check("gap_edge_cmd", n_cmd - c0, 1);
        check("gap_edge_to", n_to - t0, 0);

        // One cycle longer times out; the tail bytes are then discarded in IDLE.
        snap();
        send_byte(8'hA5);
        send_byte(8'h01);
        idle(TO_TICKS);
        send_frame(48'h10_12_34_37_00_00, 4, 0);
        idle(3);
        check("gap_over_to", n_to - t0, 1);
        check("gap_over_cmd", n_cmd - c0, 0);
        check("gap_over_busy", busy, 0);

        // Long HOLD with one injected SOF; outputs held, single transfer afterwards.
        snap();
        cmd_ready = 1'b0;
        send_frame(48'hA5_03_30_BE_EF_62, 6, 0);
        idle(20);
        send_byte(8'hA5);
        idle(79);
        check("hold_valid", cmd_valid, 1);
        check("hold_fields", {cmd_op, cmd_addr, cmd_wdata}, 32'h0330_BEEF);
        check("hold_overrun", n_ov - o0, 1);
        check("hold_no_xfer", n_cmd - c0, 0);
        cmd_ready = 1'b1;
        idle(5);
        check("hold_xfer", n_cmd - c0, 1);
        check("hold_sof_lost", busy, 0);

        // Byte arriving in the handshake cycle itself is still an overrun.
        snap();
        cmd_ready = 1'b0;
        send_frame(48'hA5_04_40_00_10_54, 6, 0);
        idle(2);
        cmd_ready = 1'b1;
        send_byte(8'hA5);
        idle(3);
        check("hs_overrun", n_ov - o0, 1);
        check("hs_xfer", n_cmd - c0, 1);
        check("hs_busy", busy, 0);

        // Reset in mid-frame discards it; the next frame decodes.
        snap();
        send_frame(48'hA5_01_10_00_00_00, 3, 0);
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        idle(2);
        check("rst_no_cmd", n_cmd - c0, 0);
        check("rst_busy", busy, 0);
        send_frame(48'hA5_05_50_AB_CD_33, 6, 0);
        idle(3);
        check("rst_after_cmd", n_cmd - c0, 1);
        check("rst_after_fields", last_cmd, 32'h0550_ABCD);

        // Random streams against the model.
        rand_ready = 1;
        for (int f = 0; f < 250; f++) begin
            if ($urandom_range(0, 7) == 0) send_byte(8'($urandom_range(0, 255)));
            fb[0] = 8'hA5;
            for (int i = 1; i < 5; i++) fb[i] = 8'($urandom_range(0, 255));
            fb[5] = fb[1] ^ fb[2] ^ fb[3] ^ fb[4];
            if ($urandom_range(0, 3) == 0) fb[5] = fb[5] ^ 8'($urandom_range(1, 255));
            fr = {fb[0], fb[1], fb[2], fb[3], fb[4], fb[5]};
            nb = ($urandom_range(0, 9) == 0) ? $urandom_range(1, 5) : 6;
            for (int i = 0; i < nb; i++) begin
                send_byte(fr[47 - 8*i -: 8]);
                gap = ($urandom_range(0, 15) == 0) ? $urandom_range(TO_TICKS - 2, TO_TICKS + 1)
                                                   : $urandom_range(0, 3);
                idle(gap);
            end
        end
        rand_ready = 0;
        cmd_ready  = 1'b1;
        idle(TO_TICKS + 10);
        check("final_queue_empty", exp_q.size(), 0);
        check("final_busy", busy, 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
